mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipeline. It consumes the EX/MEM pipeline-register outputs and contains the data memory, with word, halfword and byte access.
- It resolves the branch decision (PCSrc) back to IF.
- It holds the MEM/WB pipeline register that feeds writeback.
- It supports a stall input and flags misaligned accesses.

---
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data memory with word/half/byte access, branch
// resolution back to fetch, misalignment flagging and the MEM/WB register.
module mem_stage #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_BITS = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BranchIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic [31:0] BranchTargetAddressIn,
  input  logic [31:0] ALUIn,
  input  logic        ZeroIn,
  input  logic [31:0] MemoryWriteDataIn,
  input  logic [4:0]  DestinationRegIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic        StallIn,
  output logic        PCSrcOut,
  output logic [31:0] BranchTargetAddressOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic [31:0] MemReadDataOut,
  output logic [31:0] ALUOut,
  output logic [4:0]  DestinationRegOut,
  output logic        MisalignedOut
);

  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  logic [3:0][7:0]      dataMem [MEM_WORDS];
  logic [ADDR_BITS-1:0] wordIdx;
  logic [1:0]           byteOff;
  logic                 isHalf;
  logic                 isByte;
  logic                 isWord;
  logic                 misaligned;
  logic                 storeEn;
  logic [3:0]           byteEn;
  logic [31:0]          storeData;
  logic [31:0]          readWord;
  logic [7:0]           readByte;
  logic [15:0]          readHalf;
  logic [31:0]          loadData;
  logic                 unusedHighAddr;

  // Address bits above the memory's byte range are ignored, so accesses wrap.
  assign wordIdx        = ALUIn[ADDR_BITS+1:2];
  assign byteOff        = ALUIn[1:0];
  assign unusedHighAddr = ^ALUIn[31:ADDR_BITS+2];

  assign isHalf = (MemSizeIn == SizeHalf);
  assign isByte = (MemSizeIn == SizeByte);
  assign isWord = ~isHalf & ~isByte;

  assign misaligned = (MemReadIn | MemWriteIn) &
                      ((isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00)));

  assign storeEn = MemWriteIn & ~StallIn & ~Reset & ~misaligned;

  assign PCSrcOut               = BranchIn & ZeroIn & ~Reset;
  assign BranchTargetAddressOut = BranchTargetAddressIn;

  // Sub-word store data is replicated across lanes; byteEn picks the lane(s).
  always_comb begin
    byteEn    = 4'b0000;
    storeData = MemoryWriteDataIn;
    if (isByte) begin
      byteEn    = 4'b0001 << byteOff;
      storeData = {4{MemoryWriteDataIn[7:0]}};
    end else if (isHalf) begin
      byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
      storeData = {2{MemoryWriteDataIn[15:0]}};
    end else begin
      byteEn    = 4'b1111;
      storeData = MemoryWriteDataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (storeEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) dataMem[wordIdx][b] <= storeData[8*b +: 8];
      end
    end
  end

  // Asynchronous read yields the pre-write contents when a store hits the same edge.
  assign readWord = dataMem[wordIdx];

  always_comb begin
    readByte = 8'h00;
    case (byteOff)
      2'd0:    readByte = readWord[7:0];
      2'd1:    readByte = readWord[15:8];
      2'd2:    readByte = readWord[23:16];
      default: readByte = readWord[31:24];
    endcase
  end

  assign readHalf = byteOff[1] ? readWord[31:16] : readWord[15:0];

  always_comb begin
    loadData = 32'h0;
    if (MemReadIn & ~misaligned) begin
      if (isByte)
        loadData = {{24{MemSignedIn & readByte[7]}}, readByte};
      else if (isHalf)
        loadData = {{16{MemSignedIn & readHalf[15]}}, readHalf};
      else
        loadData = readWord;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWriteOut       <= 1'b0;
      MemToRegOut       <= 1'b0;
      MemReadDataOut    <= 32'h0;
      ALUOut            <= 32'h0;
      DestinationRegOut <= 5'd0;
      MisalignedOut     <= 1'b0;
    end else if (!StallIn) begin
      // A misaligned load must not write garbage into the register file.
      RegWriteOut       <= RegWriteIn & ~(MemReadIn & misaligned);
      MemToRegOut       <= MemToRegIn;
      MemReadDataOut    <= loadData;
      ALUOut            <= ALUIn;
      DestinationRegOut <= DestinationRegIn;
      MisalignedOut     <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte-addressed reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_mem_stage;

  localparam int MEM_WORDS = 1024;
  localparam int MEM_BYTES = 4 * MEM_WORDS;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        BranchIn, MemReadIn, MemWriteIn, RegWriteIn, MemToRegIn, ZeroIn;
  logic [31:0] BranchTargetAddressIn, ALUIn, MemoryWriteDataIn;
  logic [4:0]  DestinationRegIn;
  logic [1:0]  MemSizeIn;
  logic        MemSignedIn, StallIn;
  logic        PCSrcOut, RegWriteOut, MemToRegOut, MisalignedOut;
  logic [31:0] BranchTargetAddressOut, MemReadDataOut, ALUOut;
  logic [4:0]  DestinationRegOut;

  int errCount = 0;
  int checkCount = 0;

  mem_stage #(.MEM_WORDS(MEM_WORDS), .ADDR_BITS(10)) dut (
    .Clk(Clk), .Reset(Reset), .BranchIn(BranchIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .BranchTargetAddressIn(BranchTargetAddressIn), .ALUIn(ALUIn), .ZeroIn(ZeroIn),
    .MemoryWriteDataIn(MemoryWriteDataIn), .DestinationRegIn(DestinationRegIn),
    .MemSizeIn(MemSizeIn), .MemSignedIn(MemSignedIn), .StallIn(StallIn),
    .PCSrcOut(PCSrcOut), .BranchTargetAddressOut(BranchTargetAddressOut),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .MemReadDataOut(MemReadDataOut), .ALUOut(ALUOut),
    .DestinationRegOut(DestinationRegOut), .MisalignedOut(MisalignedOut)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte-addressed memory and expected MEM/WB contents
  logic [7:0]  mdlMem [MEM_BYTES];
  logic        started = 1'b0;
  logic        mRegWrite, mMemToReg, mMis;
  logic [31:0] mData, mAlu;
  logic [4:0]  mDst;

  initial for (int i = 0; i < MEM_BYTES; i++) mdlMem[i] = 8'h00;

  always @(posedge Clk) begin
    int unsigned a;
    int n;
    longint v;
    logic mis;
    if (Reset) begin
      started = 1'b1;
      {mRegWrite, mMemToReg, mMis} = 3'b000;
      mData = 0; mAlu = 0; mDst = 0;
    end else if (!StallIn) begin
      a = ALUIn % MEM_BYTES;
      n = (MemSizeIn == 2'b01) ? 2 : (MemSizeIn == 2'b10) ? 1 : 4;
      mis = (MemReadIn || MemWriteIn) && (a % n != 0);
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mdlMem[a + i]) << (8 * i);
      if (MemSignedIn && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v -= (64'sd1 <<< (8 * n));
      mData = (MemReadIn && !mis) ? v[31:0] : 32'h0;
      if (MemWriteIn && !mis)
        for (int i = 0; i < n; i++) mdlMem[a + i] = MemoryWriteDataIn[8*i +: 8];
      mRegWrite = RegWriteIn && !(MemReadIn && mis);
      mMemToReg = MemToRegIn;
      mAlu = ALUIn;
      mDst = DestinationRegIn;
      mMis = mis;
    end
  end

  // scoreboard compare every cycle, away from the active edge
  always @(negedge Clk) begin
    if (started) begin
      check("cmp_regwrite", {31'd0, RegWriteOut}, {31'd0, mRegWrite});
      check("cmp_memtoreg", {31'd0, MemToRegOut}, {31'd0, mMemToReg});
      check("cmp_rdata", MemReadDataOut, mData);
      check("cmp_alu", ALUOut, mAlu);
      check("cmp_dst", {27'd0, DestinationRegOut}, {27'd0, mDst});
      check("cmp_mis", {31'd0, MisalignedOut}, {31'd0, mMis});
      check("cmp_pcsrc", {31'd0, PCSrcOut}, {31'd0, BranchIn & ZeroIn & ~Reset});
      check("cmp_target", BranchTargetAddressOut, BranchTargetAddressIn);
    end
  end

  // driver tasks
  task automatic idle();
    Reset = 0; BranchIn = 0; MemReadIn = 0; MemWriteIn = 0; RegWriteIn = 0;
    MemToRegIn = 0; ZeroIn = 0; BranchTargetAddressIn = 32'h0; ALUIn = 32'h0;
    MemoryWriteDataIn = 32'h0; DestinationRegIn = 5'd0; MemSizeIn = 2'b00;
    MemSignedIn = 0; StallIn = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    idle();
    MemWriteIn = 1; ALUIn = addr; MemoryWriteDataIn = data; MemSizeIn = size;
    tick();
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    idle();
    MemReadIn = 1; RegWriteIn = 1; MemToRegIn = 1; DestinationRegIn = 5'd7;
    ALUIn = addr; MemSizeIn = size; MemSignedIn = sgn;
    tick();
  endtask

  initial begin
    idle();
    // reset clears outputs; branch masked during reset
    Reset = 1; RegWriteIn = 1; ALUIn = 32'h1234; BranchIn = 1; ZeroIn = 1;
    MemWriteIn = 1; MemoryWriteDataIn = 32'h99999999;
    #1 check("reset_pcsrc", {31'd0, PCSrcOut}, 32'd0);
    tick();
    check("reset_alu", ALUOut, 32'h0);
    check("reset_regwrite", {31'd0, RegWriteOut}, 32'd0);

    // clear the words this run touches
    store(32'h0, 32'h0, 2'b00);
    store(32'h4, 32'h0, 2'b00);
    store(32'h8, 32'h0, 2'b00);
    store(32'hC, 32'h0, 2'b00);

    // word round trip
    store(32'h8, 32'hDEADBEEF, 2'b00);
    load(32'h8, 2'b00, 1'b0);
    check("word_rt_data", MemReadDataOut, 32'hDEADBEEF);
    check("word_rt_alu", ALUOut, 32'h8);
    check("word_rt_mis", {31'd0, MisalignedOut}, 32'd0);
    check("word_rt_dst", {27'd0, DestinationRegOut}, 32'd7);

    // sub-word stores and loads
    store(32'h5, 32'h12345680, 2'b10);
    load(32'h4, 2'b00, 1'b0); check("byte_store_word", MemReadDataOut, 32'h00008000);
    load(32'h5, 2'b10, 1'b1); check("byte_signed", MemReadDataOut, 32'hFFFFFF80);
    load(32'h5, 2'b10, 1'b0); check("byte_unsigned", MemReadDataOut, 32'h00000080);
    load(32'h4, 2'b01, 1'b1); check("half_signed", MemReadDataOut, 32'hFFFF8000);
    store(32'h6, 32'hFFFFA5C3, 2'b01);
    load(32'h4, 2'b00, 1'b0); check("half_store_word", MemReadDataOut, 32'hA5C38000);
    load(32'h7, 2'b10, 1'b0); check("byte_lane3", MemReadDataOut, 32'h000000A5);
    load(32'h6, 2'b01, 1'b1); check("half_hi_signed", MemReadDataOut, 32'hFFFFA5C3);
    load(32'h6, 2'b11, 1'b0); check("size11_mis", {31'd0, MisalignedOut}, 32'd1);

    // misalignment
    store(32'hA, 32'h11111111, 2'b00);
    check("mis_store_flag", {31'd0, MisalignedOut}, 32'd1);
    load(32'h8, 2'b00, 1'b0); check("mis_store_nochange", MemReadDataOut, 32'hDEADBEEF);
    load(32'h2, 2'b00, 1'b0);
    check("mis_load_regwrite", {31'd0, RegWriteOut}, 32'd0);
    check("mis_load_data", MemReadDataOut, 32'h0);
    load(32'h5, 2'b01, 1'b1); check("mis_half_data", MemReadDataOut, 32'h0);

    // stall holds outputs and blocks the store
    idle(); ALUIn = 32'h40; tick();
    idle(); StallIn = 1; MemWriteIn = 1; ALUIn = 32'h0; MemoryWriteDataIn = 32'hCAFEF00D;
    BranchIn = 1; ZeroIn = 1; BranchTargetAddressIn = 32'h200;
    #1 check("stall_pcsrc", {31'd0, PCSrcOut}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_alu", ALUOut, 32'h40);
    end
    StallIn = 0; BranchIn = 0; tick();
    check("unstall_alu", ALUOut, 32'h0);
    load(32'h0, 2'b00, 1'b0); check("unstall_store", MemReadDataOut, 32'hCAFEF00D);

    // branch decision
    idle(); BranchIn = 1; ZeroIn = 1; BranchTargetAddressIn = 32'h100;
    #1 check("branch_taken", {31'd0, PCSrcOut}, 32'd1);
    check("branch_target", BranchTargetAddressOut, 32'h100);
    ZeroIn = 0;
    #1 check("branch_not_taken", {31'd0, PCSrcOut}, 32'd0);
    tick();

    // address wrap-around
    store(32'h100C, 32'h5A5A1234, 2'b00);
    load(32'hC, 2'b00, 1'b0); check("wrap_load", MemReadDataOut, 32'h5A5A1234);

    // simultaneous read and write returns old data
    idle(); MemReadIn = 1; MemWriteIn = 1; RegWriteIn = 1; ALUIn = 32'h8;
    MemoryWriteDataIn = 32'h01020304; tick();
    check("rw_old_data", MemReadDataOut, 32'hDEADBEEF);
    load(32'h8, 2'b00, 1'b0); check("rw_new_data", MemReadDataOut, 32'h01020304);

    // reset with stall: reset wins and the store is dropped
    idle(); Reset = 1; StallIn = 1; MemWriteIn = 1; ALUIn = 32'h0;
    MemoryWriteDataIn = 32'h77777777; tick();
    check("rst_stall_alu", ALUOut, 32'h0);
    check("rst_stall_data", MemReadDataOut, 32'h0);
    load(32'h0, 2'b00, 1'b0); check("rst_store_dropped", MemReadDataOut, 32'hCAFEF00D);

    idle(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
